vram_arbiter: RTL and testbench

- Shares one video memory instance (tile or attribute memory) between the pixel generator and a CPU-side command port.
- The pixel generator has absolute priority on the memory read port and is never stalled.
- CPU reads use only idle read-port cycles. CPU writes use the memory's separate write port.
- Sits between pixel_generator and a `memory` instance; one arbiter per shared memory.

---
 rtl/gpu_pkg.sv | 11 +
 rtl/cmd_fifo.sv | 66 ++++++
 rtl/vram_arbiter.sv | 112 +++++++++++
 tb/tb_vram_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the video memory arbiter: command entry layout
// {write, addr, wdata} and the CPU read response latency.
package gpu_pkg;

  localparam int CPU_RSP_LATENCY = 2;

  function automatic int cmd_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO, first-word-fall-through head, sync active-high reset.
// Ports: push/push_data in, pop in, head_data/full/empty/count out.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one video memory between the pixel generator (absolute read
// priority) and a queued CPU command port. GPU/CPU/memory ports below.
module vram_arbiter
  import gpu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     gpu_read_enable,
  input  logic [ADDRESS_WIDTH-1:0] gpu_read_addr,
  output logic [DATA_WIDTH-1:0]    gpu_read_data,
  input  logic                     cpu_req_valid,
  output logic                     cpu_req_ready,
  input  logic                     cpu_req_write,
  input  logic [ADDRESS_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_req_wdata,
  output logic                     cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0]    cpu_rsp_data,
  output logic                     busy,
  output logic                     mem_read_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0]    mem_read_data,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0]    mem_write_data
);

  localparam int CMDW = cmd_width(ADDRESS_WIDTH, DATA_WIDTH);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int LAT  = CPU_RSP_LATENCY;

  logic [CMDW-1:0]          push_cmd, head_cmd;
  logic                     fifo_full, fifo_empty;
  logic [CNTW-1:0]          fifo_count;
  logic                     push, pop;
  logic                     head_write;
  logic [ADDRESS_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0]    head_wdata;
  logic                     cpu_grant, wr_grant;

  logic                     gpu_last_q, gpu_last_d;
  logic [DATA_WIDTH-1:0]    gpu_hold_q, gpu_hold_d;
  logic [LAT-1:0]           rsp_pipe_q, rsp_pipe_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;

  assign push_cmd = {cpu_req_write, cpu_req_addr, cpu_req_wdata};
  assign {head_write, head_addr, head_wdata} = head_cmd;

  // Ready comes from the registered count: a full queue rejects
  // even in a cycle where it also pops.
  assign cpu_req_ready = ~fifo_full;
  assign push          = cpu_req_valid & cpu_req_ready;

  cmd_fifo #(
    .WIDTH (CMDW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .head_data (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    cpu_grant = ~rst & ~fifo_empty & ~head_write & ~gpu_read_enable;
    wr_grant  = ~rst & ~fifo_empty & head_write;
    pop       = cpu_grant | wr_grant;

    mem_read_enable  = gpu_read_enable | cpu_grant;
    mem_read_addr    = gpu_read_enable ? gpu_read_addr : head_addr;
    mem_write_enable = wr_grant;
    mem_write_addr   = head_addr;
    mem_write_data   = head_wdata;
  end

  always_comb begin
    gpu_last_d = gpu_read_enable;
    gpu_hold_d = gpu_last_q ? mem_read_data : gpu_hold_q;
    rsp_pipe_d = {rsp_pipe_q[LAT-2:0], cpu_grant};
    // Data is valid the cycle after the grant; capture it then.
    rsp_data_d = rsp_pipe_q[LAT-2] ? mem_read_data : rsp_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpu_last_q <= 1'b0;
      gpu_hold_q <= '0;
      rsp_pipe_q <= '0;
      rsp_data_q <= '0;
    end else begin
      gpu_last_q <= gpu_last_d;
      gpu_hold_q <= gpu_hold_d;
      rsp_pipe_q <= rsp_pipe_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Bypass on the return cycle keeps GPU latency at one memory cycle.
  assign gpu_read_data = gpu_last_q ? mem_read_data : gpu_hold_q;
  assign cpu_rsp_valid = rsp_pipe_q[LAT-1];
  assign cpu_rsp_data  = rsp_data_q;
  assign busy          = (fifo_count != '0) | (|rsp_pipe_q);

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural memory, CPU response scoreboard,
// one task per scenario.
module tb_vram_arbiter;

  logic        clk;
  logic        rst;
  logic        gpu_read_enable;
  logic [11:0] gpu_read_addr;
  logic [7:0]  gpu_read_data;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_write;
  logic [11:0] cpu_req_addr;
  logic [7:0]  cpu_req_wdata;
  logic        cpu_rsp_valid;
  logic [7:0]  cpu_rsp_data;
  logic        busy;
  logic        mem_read_enable;
  logic [11:0] mem_read_addr;
  logic [7:0]  mem_read_data;
  logic        mem_write_enable;
  logic [11:0] mem_write_addr;
  logic [7:0]  mem_write_data;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int rsp_seen = 0;

  logic [7:0] mem    [4096];
  logic [7:0] shadow [4096];
  logic [7:0] exp_q  [$];

  vram_arbiter #(
    .ADDRESS_WIDTH (12),
    .DATA_WIDTH    (8),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .gpu_read_enable  (gpu_read_enable),
    .gpu_read_addr    (gpu_read_addr),
    .gpu_read_data    (gpu_read_data),
    .cpu_req_valid    (cpu_req_valid),
    .cpu_req_ready    (cpu_req_ready),
    .cpu_req_write    (cpu_req_write),
    .cpu_req_addr     (cpu_req_addr),
    .cpu_req_wdata    (cpu_req_wdata),
    .cpu_rsp_valid    (cpu_rsp_valid),
    .cpu_rsp_data     (cpu_rsp_data),
    .busy             (busy),
    .mem_read_enable  (mem_read_enable),
    .mem_read_addr    (mem_read_addr),
    .mem_read_data    (mem_read_data),
    .mem_write_enable (mem_write_enable),
    .mem_write_addr   (mem_write_addr),
    .mem_write_data   (mem_write_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [11:0] a);
    return 8'(a ^ (a >> 4)) ^ 8'h5A;
  endfunction

  // Memory: registered read, read-before-write on same address.
  always @(posedge clk) begin
    if (mem_read_enable) mem_read_data <= mem[mem_read_addr];
    if (mem_write_enable) mem[mem_write_addr] <= mem_write_data;
  end

  // Scoreboard producer: expected read data fixed at acceptance time.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 4096; i++) shadow[i] = mem[i];
    end else if (cpu_req_valid && cpu_req_ready) begin
      accepted++;
      if (cpu_req_write) shadow[cpu_req_addr] = cpu_req_wdata;
      else exp_q.push_back(shadow[cpu_req_addr]);
    end
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!rst && cpu_rsp_valid) begin
      checks++;
      rsp_seen++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got %h required none", cpu_rsp_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (cpu_rsp_data !== e) begin
          errors++;
          $display("FAIL rsp_data got %h required %h", cpu_rsp_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    cpu_req_valid = 1;
    cpu_req_write = 1;
    cpu_req_addr = 12'h007;
    cpu_req_wdata = 8'h33;
    step();
    @(negedge clk);
    checks++;
    if ({cpu_req_ready, busy, cpu_rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags got rdy/busy/rsp %b%b%b required 100",
               cpu_req_ready, busy, cpu_rsp_valid);
    end
    checks++;
    if ({mem_read_enable, mem_write_enable} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mem_en got %b%b required 00",
               mem_read_enable, mem_write_enable);
    end
    checks++;
    if ({gpu_read_data, cpu_rsp_data} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data got %h %h required 00 00",
               gpu_read_data, cpu_rsp_data);
    end
    step();
    rst = 0;
    cpu_req_valid = 0;
    @(negedge clk);
    checks++;
    if ({busy, mem_write_enable} !== 2'b00) begin
      errors++;
      $display("FAIL reset_empty got busy/wen %b%b required 00",
               busy, mem_write_enable);
    end
    step();
  endtask

  task automatic test_write_read();
    cpu_req_valid = 1;
    cpu_req_write = 1;
    cpu_req_addr = 12'h010;
    cpu_req_wdata = 8'hA5;
    step();
    cpu_req_write = 0;
    cpu_req_wdata = 8'h00;
    @(negedge clk);
    checks++;
    if ({mem_write_enable, mem_write_addr, mem_write_data, mem_read_enable}
        !== {1'b1, 12'h010, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL wr_issue got en %b addr %h data %h ren %b required 1 010 a5 0",
               mem_write_enable, mem_write_addr, mem_write_data,
               mem_read_enable);
    end
    step();
    cpu_req_valid = 0;
    @(negedge clk);
    checks++;
    if ({mem_write_enable, mem_read_enable, mem_read_addr}
        !== {1'b0, 1'b1, 12'h010}) begin
      errors++;
      $display("FAIL rd_grant got wen %b ren %b addr %h required 0 1 010",
               mem_write_enable, mem_read_enable, mem_read_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if (cpu_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_early got %b required 0", cpu_rsp_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if ({cpu_rsp_valid, cpu_rsp_data} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL rsp_n2 got %b %h required 1 a5",
               cpu_rsp_valid, cpu_rsp_data);
    end
    step();
    @(negedge clk);
    checks++;
    if ({cpu_rsp_valid, cpu_rsp_data, busy} !== {1'b0, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL rsp_hold got %b %h busy %b required 0 a5 0",
               cpu_rsp_valid, cpu_rsp_data, busy);
    end
    step();
  endtask

  task automatic test_gpu_saturate();
    gpu_read_enable = 1;
    gpu_read_addr = 12'h200;
    cpu_req_valid = 1;
    cpu_req_write = 0;
    cpu_req_addr = 12'h020;
    step();
    cpu_req_valid = 0;
    for (int k = 0; k < 6; k++) begin
      gpu_read_addr = 12'(12'h200 + k);
      @(negedge clk);
      checks++;
      if ({mem_read_enable, mem_read_addr, cpu_rsp_valid, busy}
          !== {1'b1, gpu_read_addr, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL sat_%0d got ren %b addr %h rsp %b busy %b required 1 %h 0 1",
                 k, mem_read_enable, mem_read_addr, cpu_rsp_valid, busy,
                 gpu_read_addr);
      end
      step();
    end
    gpu_read_enable = 0;
    @(negedge clk);
    checks++;
    if ({mem_read_enable, mem_read_addr} !== {1'b1, 12'h020}) begin
      errors++;
      $display("FAIL sat_grant got %b %h required 1 020",
               mem_read_enable, mem_read_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if (cpu_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_rsp_early got %b required 0", cpu_rsp_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if ({cpu_rsp_valid, cpu_rsp_data} !== {1'b1, init_val(12'h020)}) begin
      errors++;
      $display("FAIL sat_rsp got %b %h required 1 %h",
               cpu_rsp_valid, cpu_rsp_data, init_val(12'h020));
    end
    step();
  endtask

  task automatic test_interleave();
    int base;
    logic prev_gpu;
    logic [11:0] prev_addr;
    logic have_exp;
    logic [7:0] exp_gpu;
    base = rsp_seen;
    prev_gpu = 0;
    prev_addr = '0;
    have_exp = 0;
    exp_gpu = '0;
    for (int c = 0; c < 24; c++) begin
      gpu_read_enable = (c % 2 == 0);
      gpu_read_addr = 12'(12'h100 + c);
      cpu_req_valid = (c < 4);
      cpu_req_write = 0;
      cpu_req_addr = 12'(12'h030 + c);
      @(negedge clk);
      if (prev_gpu) begin
        exp_gpu = init_val(prev_addr);
        have_exp = 1;
      end
      if (have_exp) begin
        checks++;
        if (gpu_read_data !== exp_gpu) begin
          errors++;
          $display("FAIL gpu_data_c%0d got %h required %h",
                   c, gpu_read_data, exp_gpu);
        end
      end
      prev_gpu = gpu_read_enable;
      prev_addr = gpu_read_addr;
      step();
    end
    cpu_req_valid = 0;
    gpu_read_enable = 0;
    checks++;
    if (rsp_seen - base != 4) begin
      errors++;
      $display("FAIL interleave_count got %0d required 4", rsp_seen - base);
    end
  endtask

  task automatic test_full();
    int acc_base;
    int rsp_base;
    int n;
    acc_base = accepted;
    rsp_base = rsp_seen;
    gpu_read_enable = 1;
    gpu_read_addr = 12'h300;
    cpu_req_write = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_req_valid = 1;
      cpu_req_addr = 12'(12'h040 + i);
      @(negedge clk);
      checks++;
      if (cpu_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_fill_%0d got ready %b required 1",
                 i, cpu_req_ready);
      end
      step();
    end
    cpu_req_addr = 12'h044;
    @(negedge clk);
    checks++;
    if (cpu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b required 0", cpu_req_ready);
    end
    step();
    gpu_read_enable = 0;
    @(negedge clk);
    checks++;
    if ({cpu_req_ready, mem_read_enable, mem_read_addr}
        !== {1'b0, 1'b1, 12'h040}) begin
      errors++;
      $display("FAIL full_pop_cycle got rdy %b ren %b addr %h required 0 1 040",
               cpu_req_ready, mem_read_enable, mem_read_addr);
    end
    step();
    gpu_read_enable = 1;
    @(negedge clk);
    checks++;
    if (cpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_reopen got %b required 1", cpu_req_ready);
    end
    step();
    cpu_req_valid = 0;
    gpu_read_enable = 0;
    checks++;
    if (accepted - acc_base != 5) begin
      errors++;
      $display("FAIL full_accepted got %0d required 5", accepted - acc_base);
    end
    n = 0;
    while (rsp_seen - rsp_base < 5 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (rsp_seen - rsp_base != 5) begin
      errors++;
      $display("FAIL full_drain got %0d required 5", rsp_seen - rsp_base);
    end
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL full_idle got busy %b required 0", busy);
    end
    step();
  endtask

  task automatic test_reset_mid();
    gpu_read_enable = 1;
    gpu_read_addr = 12'h400;
    cpu_req_valid = 1;
    cpu_req_write = 0;
    cpu_req_addr = 12'h050;
    step();
    cpu_req_addr = 12'h051;
    step();
    cpu_req_write = 1;
    cpu_req_addr = 12'h060;
    cpu_req_wdata = 8'h11;
    step();
    cpu_req_addr = 12'h062;
    cpu_req_wdata = 8'h22;
    step();
    cpu_req_valid = 0;
    cpu_req_write = 0;
    gpu_read_enable = 0;
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b required 1", busy);
    end
    rst = 1;
    step();
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, mem_write_enable, cpu_rsp_valid} !== 3'b000) begin
        errors++;
        $display("FAIL mid_after_%0d got busy %b wen %b rsp %b required 000",
                 k, busy, mem_write_enable, cpu_rsp_valid);
      end
      step();
    end
    checks++;
    if (mem[12'h060] !== init_val(12'h060)) begin
      errors++;
      $display("FAIL mid_mem got %h required %h",
               mem[12'h060], init_val(12'h060));
    end
  endtask

  initial begin
    clk = 0;
    rst = 1;
    gpu_read_enable = 0;
    gpu_read_addr = '0;
    cpu_req_valid = 0;
    cpu_req_write = 0;
    cpu_req_addr = '0;
    cpu_req_wdata = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = init_val(12'(i));
      shadow[i] = init_val(12'(i));
    end
    test_reset();
    test_write_read();
    test_gpu_saturate();
    test_interleave();
    test_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
